// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entry layout, bubble encoding and PC increment.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] BUBBLE_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries.
// Push, pop and flush; flush empties the queue in one edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wr_data,
    output fetch_entry_t  head_data,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    // Pointer and occupancy update; reset beats flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[tail] <= wr_data;
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: drives imem PC, queues {pc, instr}, feeds decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter  int          DEPTH    = 4,
    parameter  logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int          CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          jump_en,
    input  logic [31:0]   jump_dest,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_ready,
    output logic          d_valid,
    output logic [31:0]   d_pc,
    output logic [31:0]   d_instr,
    output logic [CW-1:0] q_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_flushed
`endif
);

    logic [31:0]  fetch_pc;
    logic         push;
    logic         pop;
    logic         flush;
    fetch_entry_t wr_entry;
    fetch_entry_t head_entry;

    // A redirect suppresses both queue ports for that edge
    assign flush = jump_en;
    assign pop   = !stall && (q_count != '0) && !jump_en;
    assign push  = imem_ready
                && ((q_count < CW'(DEPTH)) || pop)
                && !jump_en;

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wr_data   (wr_entry),
        .head_data (head_entry),
        .count     (q_count)
    );

    // Fetch address: redirect to word-aligned target, else step on push
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (jump_en) begin
            fetch_pc <= jump_dest & ~32'd3;
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    assign imem_addr = fetch_pc;

    // Head presented to decode, bubble when the queue is empty
    always_comb begin
        d_valid = (q_count != '0);
        d_pc    = 32'd0;
        d_instr = BUBBLE_INSTR;
        if (d_valid) begin
            d_pc    = head_entry.pc;
            d_instr = head_entry.instr;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] flush_sum;

    assign flush_sum = {1'b0, perf_flushed} + 33'(q_count);

    // Saturating counters; a jump does not clear them
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (jump_en) begin
                perf_flushed <= flush_sum[32] ? 32'hFFFF_FFFF
                                              : flush_sum[31:0];
            end
        end
    end
`endif

endmodule
